// File: rtl/resp_tracker_l2.sv
// Response tracker for one L2 bank: follows accepted requests through the fixed
// SRAM read latency and returns data/tag to the requesting initiator.
module resp_tracker_l2 #(
    parameter int DATA_WIDTH  = 64,
    parameter int TAG_WIDTH   = DATA_WIDTH / 8,
    parameter int N_INIT      = 4,
    parameter int ID_WIDTH    = $clog2(N_INIT),
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  grant_i,
    input  logic                  wen_i,
    input  logic [ID_WIDTH-1:0]   id_i,
    input  logic [TAG_WIDTH-1:0]  tag_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [N_INIT-1:0]     data_r_valid_o,
    output logic [DATA_WIDTH-1:0] data_r_rdata_o,
    output logic [TAG_WIDTH-1:0]  data_r_rtag_o,
    output logic [2:0]            outstanding_o
);

    localparam int LAST = MEM_LATENCY - 1;

    logic [MEM_LATENCY-1:0] vld_q;
    logic [MEM_LATENCY-1:0] wen_q;
    logic [ID_WIDTH-1:0]    id_q  [MEM_LATENCY];
    logic [TAG_WIDTH-1:0]   tag_q [MEM_LATENCY];

    logic [N_INIT-1:0]      onehot;
    logic                   resp_q;

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value and the shift stays ordered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= grant_i;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // NOTE: payload stages carry no reset; a stale payload is harmless because
    // it is only ever consumed while its valid bit is set.
    always_ff @(posedge clk) begin
        wen_q[0] <= wen_i;
        id_q[0]  <= id_i;
        tag_q[0] <= tag_i;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            wen_q[i] <= wen_q[i-1];
            id_q[i]  <= id_q[i-1];
            tag_q[i] <= tag_q[i-1];
        end
    end

    // Out-of-range ids match no bit and therefore raise no valid.
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < N_INIT; i++) begin
            if (id_q[LAST] == ID_WIDTH'(i)) begin
                onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r_valid_o <= '0;
            data_r_rdata_o <= '0;
            data_r_rtag_o  <= '0;
            resp_q         <= 1'b0;
        end else begin
            resp_q         <= vld_q[LAST];
            data_r_valid_o <= vld_q[LAST] ? onehot : '0;
            if (vld_q[LAST]) begin
                data_r_rtag_o  <= tag_q[LAST];
                data_r_rdata_o <= wen_q[LAST] ? '0 : mem_rdata_i;
            end
        end
    end

    // A request retires at the end of its response cycle, including illegal-id
    // requests that never show a valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_o <= '0;
        end else begin
            case ({grant_i, resp_q})
                2'b10:   outstanding_o <= outstanding_o + 3'd1;
                2'b01:   outstanding_o <= outstanding_o - 3'd1;
                default: outstanding_o <= outstanding_o;
            endcase
        end
    end

endmodule

// File: tb/tb_resp_tracker_l2.sv
// Scoreboard bench: three trackers (latency 1..3) share one stimulus stream and
// are checked against an edge-indexed request/response model.
module tb_resp_tracker_l2;

    localparam int DW = 64;
    localparam int TW = 8;
    localparam int NI = 4;
    localparam int IW = 3;
    localparam int ND = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          grant;
    logic          wen;
    logic [IW-1:0] id;
    logic [TW-1:0] tag;
    logic [DW-1:0] mem_rdata;

    logic [NI-1:0] valid       [ND];
    logic [DW-1:0] rdata       [ND];
    logic [TW-1:0] rtag        [ND];
    logic [2:0]    outstanding [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        resp_tracker_l2 #(
            .DATA_WIDTH (DW),
            .TAG_WIDTH  (TW),
            .N_INIT     (NI),
            .ID_WIDTH   (IW),
            .MEM_LATENCY(g + 1)
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .grant_i       (grant),
            .wen_i         (wen),
            .id_i          (id),
            .tag_i         (tag),
            .mem_rdata_i   (mem_rdata),
            .data_r_valid_o(valid[g]),
            .data_r_rdata_o(rdata[g]),
            .data_r_rtag_o (rtag[g]),
            .outstanding_o (outstanding[g])
        );
    end

    typedef struct {
        int            due;
        logic          wen;
        int            id;
        logic [TW-1:0] tag;
    } req_t;

    req_t          sbq [ND][$];
    int            gq  [ND][$];
    logic [DW-1:0] mem_hist [int];
    logic [DW-1:0] exp_rdata [ND];
    logic [TW-1:0] exp_rtag  [ND];

    int edge_cnt    = 0;
    int vectors     = 0;
    int miscompares = 0;
    bit mon_en      = 1'b0;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @edge %0d: got %h expected %h", name, edge_cnt, act, exp);
        end
    endtask

    // Monitor: after edge X, a request granted at edge g shows its response
    // when g+L == X and is still counted outstanding while g <= X < g+L+1.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < ND; d++) begin
                int            x;
                int            cnt;
                logic [NI-1:0] ev;
                req_t          r;
                x  = edge_cnt;
                ev = '0;
                while (sbq[d].size() > 0 && sbq[d][0].due < x) begin
                    r = sbq[d].pop_front();
                    check($sformatf("lost_resp_l%0d", d + 1), 64'(r.due), 64'(x));
                end
                if (sbq[d].size() > 0 && sbq[d][0].due == x) begin
                    r = sbq[d].pop_front();
                    if (r.id < NI) ev[r.id] = 1'b1;
                    exp_rtag[d]  = r.tag;
                    exp_rdata[d] = r.wen ? '0 : mem_hist[x];
                end
                check($sformatf("valid_l%0d", d + 1), 64'(valid[d]), 64'(ev));
                check($sformatf("rtag_l%0d", d + 1),  64'(rtag[d]),  64'(exp_rtag[d]));
                check($sformatf("rdata_l%0d", d + 1), rdata[d],      exp_rdata[d]);
                while (gq[d].size() > 0 && gq[d][0] + d + 2 <= x) void'(gq[d].pop_front());
                cnt = 0;
                foreach (gq[d][k]) if (gq[d][k] <= x) cnt++;
                check($sformatf("outstanding_l%0d", d + 1), 64'(outstanding[d]), 64'(cnt));
            end
        end
    end

    // Called just after a negedge: sets inputs for the next rising edge, logs the
    // request into the model, then waits for the following negedge.
    task automatic drive(input bit g, input bit w, input int i, input logic [TW-1:0] t,
                         input logic [DW-1:0] m);
        int e;
        e         = edge_cnt + 1;
        grant     = g;
        wen       = w;
        id        = IW'(i);
        tag       = t;
        mem_rdata = m;
        mem_hist[e] = m;
        if (g) begin
            for (int d = 0; d < ND; d++) begin
                req_t r;
                r.due = e + d + 1;
                r.wen = w;
                r.id  = i;
                r.tag = t;
                sbq[d].push_back(r);
                gq[d].push_back(e);
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            drive(1'b0, 1'($urandom), int'($urandom_range(0, 7)), TW'($urandom), rnd_data());
    endtask

    task automatic check_all_zero(input string name);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("%s_valid_l%0d", name, d + 1), 64'(valid[d]), 64'd0);
            check($sformatf("%s_rdata_l%0d", name, d + 1), rdata[d], 64'd0);
            check($sformatf("%s_rtag_l%0d", name, d + 1), 64'(rtag[d]), 64'd0);
            check($sformatf("%s_outst_l%0d", name, d + 1), 64'(outstanding[d]), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        grant = 1'b0;
        wen = 1'b0;
        id = '0;
        tag = '0;
        mem_rdata = '0;
        for (int d = 0; d < ND; d++) begin
            exp_rdata[d] = '0;
            exp_rtag[d]  = '0;
        end
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        mon_en = 1'b1;
        rst_n  = 1'b1;

        // Read id=2 tag=0x5A; 0xDEAD on the bus one edge later (latency-1 slot).
        drive(1'b1, 1'b0, 2, 8'h5A, 64'h1111);
        drive(1'b0, 1'b0, 0, 8'h00, 64'hDEAD);
        idle(5);

        // Write id=1 tag=0x03 returns zero data.
        drive(1'b1, 1'b1, 1, 8'h03, rnd_data());
        idle(5);

        // Eight back-to-back reads cycling through every initiator.
        for (int k = 0; k < 8; k++) drive(1'b1, 1'b0, k % NI, TW'(8'h10 + k), rnd_data());
        idle(6);

        // Inputs toggling with no grant.
        idle(20);

        // Illegal initiator index.
        drive(1'b1, 1'b0, 5, 8'hEE, rnd_data());
        idle(6);

        // Two grants, then reset midway through the second cycle.
        drive(1'b1, 1'b0, 3, 8'hA1, rnd_data());
        drive(1'b1, 1'b0, 0, 8'hA2, rnd_data());
        grant = 1'b0;
        #2;
        rst_n = 1'b0;
        for (int d = 0; d < ND; d++) begin
            sbq[d].delete();
            gq[d].delete();
            exp_rdata[d] = '0;
            exp_rtag[d]  = '0;
        end
        #1;
        check_all_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Random traffic with occasional illegal ids.
        for (int k = 0; k < 300; k++)
            drive(1'($urandom_range(0, 9) < 7), 1'($urandom), int'($urandom_range(0, 4)),
                  TW'($urandom), rnd_data());
        idle(8);

        for (int d = 0; d < ND; d++)
            check($sformatf("drained_l%0d", d + 1), 64'(sbq[d].size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
